// File: rtl/store_buffer_pkg.sv
// store_buffer_pkg: definitions shared by the store buffer files.
//   - ST_* FSM state encodings (IDLE=0, DRAIN=1, LOAD=2)
//   - DEFAULT_DEPTH, the default number of buffered stores
//   - sb_entry_t, the 68-bit buffered store {addr, data, sign_mask}
//   - word_addr(), the word-address slice used by the hazard compare
package store_buffer_pkg;

  localparam int DEFAULT_DEPTH = 4;
  localparam int ENTRY_W       = 68;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_LOAD  = 2'd2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  sign_mask;
  } sb_entry_t;

  // Word address of a byte address: size and byte offset do not matter for ordering.
  function automatic logic [29:0] word_addr(input logic [31:0] byte_addr);
    return byte_addr[31:2];
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// store_buffer_if: data-memory bus between the store buffer and data memory.
//   master (store buffer): drives mem_req, mem_we, mem_addr, mem_wdata, mem_sign_mask
//                          and receives mem_ready, mem_rdata.
//   slave  (memory):       the mirror image.
// mem_req is held until a one-cycle mem_ready; mem_rdata is valid with mem_ready.
interface store_buffer_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sign_mask;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sign_mask,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sign_mask,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/sb_fifo.sv
// sb_fifo: DEPTH-entry register FIFO of buffered stores.
//   clk, reset   : clock, synchronous active-high reset
//   push, entry  : write entry at tail (ignored when full)
//   pop          : drop head entry (ignored when empty)
//   head_entry   : oldest entry
//   full, empty, count : occupancy, count in 0..DEPTH
//   cmp_word     : word address of the incoming load
//   hit_vec      : per-slot match of a valid entry against cmp_word
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  sb_entry_t        entry,
  input  logic             pop,
  input  logic [29:0]      cmp_word,
  output sb_entry_t        head_entry,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count,
  output logic [DEPTH-1:0] hit_vec
);

  localparam logic [PTR_W:0]   ONE_C     = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] PTR_ONE_C = ONE_C[PTR_W-1:0];
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(DEPTH);

  sb_entry_t        slots_r [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [PTR_W:0]   count_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Occupancy flags and guarded push/pop.
  always_comb begin
    full      = (count_r == DEPTH_C);
    empty     = (count_r == {(PTR_W + 1){1'b0}});
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
  end

  assign count      = count_r;
  assign head_entry = slots_r[head_r];

  // Storage, pointers and count; full is sampled before a same-cycle pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {(PTR_W + 1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        slots_r[i] <= {ENTRY_W{1'b0}};
      end
    end else begin
      if (push_ok_s) begin
        slots_r[tail_r] <= entry;
        tail_r          <= tail_r + PTR_ONE_C;
      end
      if (pop_ok_s) begin
        head_r <= head_r + PTR_ONE_C;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // A slot is live when its distance from head (mod DEPTH) is below count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_hit
    logic [PTR_W-1:0] off_s;
    assign off_s      = PTR_W'(g) - head_r;
    assign hit_vec[g] = ({1'b0, off_s} < count_r) &&
                        (word_addr(slots_r[g].addr) == cmp_word);
  end

endmodule

// File: rtl/store_buffer.sv
// store_buffer: posted-write buffer between the CPU load/store path and data memory.
//   clk, reset          : clock, synchronous active-high reset
//   addr, write_data    : CPU byte address and store data
//   memwrite, memread   : CPU store / load request (memread wins if both)
//   sign_mask           : CPU access code, passed through to memory
//   read_data           : registered load result
//   clk_stall           : combinational CPU hold
//   mem                 : data-memory bus (master side)
// Stores are queued and drained in order; a load overtakes queued stores unless
// it hits one of their word addresses, in which case drains run until it clears.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:0]    addr,
  input  logic [31:0]    write_data,
  input  logic           memwrite,
  input  logic           memread,
  input  logic [3:0]     sign_mask,
  output logic [31:0]    read_data,
  output logic           clk_stall,
  store_buffer_if.master mem
);

  logic [1:0]       state_r;
  logic             done_r;
  logic [31:0]      read_data_r;
  logic             mem_req_r;
  logic             mem_we_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic [3:0]       mem_mask_r;

  logic             push_s;
  logic             pop_s;
  logic             hit_s;
  logic             full_s;
  logic             empty_s;
  logic [PTR_W:0]   count_s;
  logic [DEPTH-1:0] hit_vec_s;
  sb_entry_t        head_s;
  sb_entry_t        push_entry_s;

  assign push_entry_s = '{addr: addr, data: write_data, sign_mask: sign_mask};

  sb_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push_s),
    .entry      (push_entry_s),
    .pop        (pop_s),
    .cmp_word   (word_addr(addr)),
    .head_entry (head_s),
    .full       (full_s),
    .empty      (empty_s),
    .count      (count_s),
    .hit_vec    (hit_vec_s)
  );

  // Queue control, hazard detect and CPU stall; done_r releases exactly one load.
  always_comb begin
    push_s    = memwrite & ~memread & ~full_s & ~reset;
    pop_s     = (state_r == ST_DRAIN) & mem.mem_ready & ~empty_s & ~reset;
    hit_s     = memread & (|hit_vec_s);
    clk_stall = (memwrite & full_s) | (memread & ~done_r);
  end

  // Memory FSM; bus outputs are loaded on the transition into DRAIN or LOAD.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      done_r      <= 1'b0;
      read_data_r <= 32'h0;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0;
      mem_wdata_r <= 32'h0;
      mem_mask_r  <= 4'h0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // done_r blocks re-issuing the load the CPU is still presenting.
          if (memread && !hit_s && !done_r) begin
            state_r     <= ST_LOAD;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= addr;
            mem_wdata_r <= write_data;
            mem_mask_r  <= sign_mask;
          end else if (count_s != {(PTR_W + 1){1'b0}}) begin
            state_r     <= ST_DRAIN;
            mem_req_r   <= 1'b1;
            mem_we_r    <= 1'b1;
            mem_addr_r  <= head_s.addr;
            mem_wdata_r <= head_s.data;
            mem_mask_r  <= head_s.sign_mask;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (mem.mem_ready) begin
            state_r   <= ST_IDLE;
            mem_req_r <= 1'b0;
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_LOAD: begin
          if (mem.mem_ready) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            read_data_r <= mem.mem_rdata;
            done_r      <= 1'b1;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign read_data         = read_data_r;
  assign mem.mem_req       = mem_req_r;
  assign mem.mem_we        = mem_we_r;
  assign mem.mem_addr      = mem_addr_r;
  assign mem.mem_wdata     = mem_wdata_r;
  assign mem.mem_sign_mask = mem_mask_r;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scenario tasks for store_buffer with a memory-transaction
// scoreboard. Expected bus transactions are queued in memory order as stimulus is
// driven and checked as each one completes (mem_req & mem_ready at posedge).
// Inputs change on negedge; outputs are checked on negedge (or #1 after it for
// the combinational stall).
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic        memwrite = 1'b0;
  logic        memread = 1'b0;
  logic [3:0]  sign_mask = 4'h0;
  logic [31:0] read_data;
  logic        clk_stall;

  store_buffer_if mem_bus();

  store_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .addr       (addr),
    .write_data (write_data),
    .memwrite   (memwrite),
    .memread    (memread),
    .sign_mask  (sign_mask),
    .read_data  (read_data),
    .clk_stall  (clk_stall),
    .mem        (mem_bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Scoreboard: every completed memory transaction must match the queue head.
  always @(posedge clk) begin : mon
    exp_t e;
    if (!reset && mem_bus.mem_req && mem_bus.mem_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL mem_txn: got we=%0b addr=%h with no transaction expected",
                 mem_bus.mem_we, mem_bus.mem_addr);
      end else begin
        e = exp_q.pop_front();
        if (mem_bus.mem_we !== e.we || mem_bus.mem_addr !== e.addr ||
            mem_bus.mem_sign_mask !== e.mask ||
            (e.we && mem_bus.mem_wdata !== e.wdata)) begin
          n_err++;
          $display("FAIL mem_txn: got we=%0b addr=%h wdata=%h mask=%b, expected we=%0b addr=%h wdata=%h mask=%b",
                   mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata, mem_bus.mem_sign_mask,
                   e.we, e.addr, e.wdata, e.mask);
        end
      end
    end
  end

  task automatic drive_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    memwrite = 1'b1; memread = 1'b0; addr = a; write_data = d; sign_mask = m;
  endtask

  task automatic drive_load(input logic [31:0] a, input logic [3:0] m);
    memwrite = 1'b0; memread = 1'b1; addr = a; sign_mask = m;
  endtask

  task automatic cpu_idle();
    memwrite = 1'b0; memread = 1'b0;
  endtask

  // Waits (bounded) on negedges for mem_req; ok=0 on timeout.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_bus.mem_req === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  // One-cycle mem_ready pulse starting at the current negedge.
  task automatic mem_pulse(input logic [31:0] rd);
    mem_bus.mem_ready = 1'b1;
    mem_bus.mem_rdata = rd;
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL reset_read_data: got %h expected %h", read_data, 32'h0); end
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b expected 0", mem_bus.mem_req); end
    n_cmp++; if (clk_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", clk_stall); end
    reset = 1'b0;
    @(negedge clk);
    mem_pulse(32'h0000_0055);
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL stray_ready_req: got %b expected 0", mem_bus.mem_req); end
    n_cmp++; if (read_data !== 32'h0) begin n_err++; $display("FAIL stray_ready_data: got %h expected %h", read_data, 32'h0); end
  endtask

  task automatic test_fill_stall();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      drive_store(32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
      exp_q.push_back('{1'b1, 32'h1000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF});
      #1;
      n_cmp++; if (clk_stall !== 1'b0) begin n_err++; $display("FAIL fill_no_stall[%0d]: got %b expected 0", i, clk_stall); end
      @(negedge clk);
    end
    n_cmp++; if (dut.count_s !== 3'd4) begin n_err++; $display("FAIL fill_count: got %0d expected 4", dut.count_s); end
    drive_store(32'h1010, 32'hA4, 4'hF);
    exp_q.push_back('{1'b1, 32'h1010, 32'hA4, 4'hF});
    #1;
    n_cmp++; if (clk_stall !== 1'b1) begin n_err++; $display("FAIL full_stall: got %b expected 1", clk_stall); end
    repeat (2) begin
      @(negedge clk);
      n_cmp++; if (clk_stall !== 1'b1) begin n_err++; $display("FAIL full_stall_hold: got %b expected 1", clk_stall); end
    end
    n_cmp++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_addr !== 32'h1000) begin
      n_err++; $display("FAIL drain_head: got req=%b addr=%h expected req=1 addr=%h", mem_bus.mem_req, mem_bus.mem_addr, 32'h1000);
    end
    mem_bus.mem_ready = 1'b1;
    #1;
    n_cmp++; if (clk_stall !== 1'b1) begin n_err++; $display("FAIL stall_during_pop: got %b expected 1", clk_stall); end
    @(negedge clk);
    mem_bus.mem_ready = 1'b0;
    #1;
    n_cmp++; if (clk_stall !== 1'b0) begin n_err++; $display("FAIL stall_release: got %b expected 0", clk_stall); end
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL req_drop_after_ready: got %b expected 0", mem_bus.mem_req); end
    @(negedge clk);
    cpu_idle();
    n_cmp++; if (dut.count_s !== 3'd4) begin n_err++; $display("FAIL refill_count: got %0d expected 4", dut.count_s); end
    for (int i = 0; i < 4; i++) begin
      wait_req(ok);
      n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL drain_timeout[%0d]: got no mem_req expected mem_req", i); end
      mem_pulse(32'h0);
      n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL drain_gap[%0d]: got %b expected 0", i, mem_bus.mem_req); end
    end
  endtask

  task automatic test_hazard();
    bit ok;
    drive_store(32'h1004, 32'hDEAD_BEEF, 4'hF);
    exp_q.push_back('{1'b1, 32'h1004, 32'hDEAD_BEEF, 4'hF});
    @(negedge clk);
    drive_load(32'h1006, 4'b0011);
    exp_q.push_back('{1'b0, 32'h1006, 32'h0, 4'b0011});
    #1;
    n_cmp++; if (clk_stall !== 1'b1) begin n_err++; $display("FAIL hazard_stall: got %b expected 1", clk_stall); end
    repeat (3) begin
      @(negedge clk);
      n_cmp++; if (clk_stall !== 1'b1) begin n_err++; $display("FAIL hazard_stall_hold: got %b expected 1", clk_stall); end
    end
    n_cmp++; if (mem_bus.mem_req !== 1'b1 || mem_bus.mem_we !== 1'b1) begin
      n_err++; $display("FAIL hazard_drain_first: got req=%b we=%b expected req=1 we=1", mem_bus.mem_req, mem_bus.mem_we);
    end
    mem_pulse(32'h0);
    n_cmp++; if (clk_stall !== 1'b1) begin n_err++; $display("FAIL hazard_stall_after_drain: got %b expected 1", clk_stall); end
    wait_req(ok);
    n_cmp++; if (ok !== 1'b1 || mem_bus.mem_we !== 1'b0) begin
      n_err++; $display("FAIL hazard_load_issue: got ok=%b we=%b expected ok=1 we=0", ok, mem_bus.mem_we);
    end
    mem_pulse(32'h1234_5678);
    n_cmp++; if (read_data !== 32'h1234_5678) begin n_err++; $display("FAIL hazard_read_data: got %h expected %h", read_data, 32'h1234_5678); end
    n_cmp++; if (clk_stall !== 1'b0) begin n_err++; $display("FAIL hazard_release: got %b expected 0", clk_stall); end
    cpu_idle();
    @(negedge clk);
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL no_repeat_load: got %b expected 0", mem_bus.mem_req); end
    n_cmp++; if (read_data !== 32'h1234_5678) begin n_err++; $display("FAIL read_data_hold: got %h expected %h", read_data, 32'h1234_5678); end
  endtask

  task automatic test_bypass();
    bit ok;
    drive_store(32'h1000, 32'h77, 4'hF);
    @(negedge clk);
    drive_load(32'h1040, 4'hF);
    exp_q.push_back('{1'b0, 32'h1040, 32'h0, 4'hF});
    exp_q.push_back('{1'b1, 32'h1000, 32'h77, 4'hF});
    wait_req(ok);
    n_cmp++; if (ok !== 1'b1 || mem_bus.mem_we !== 1'b0) begin
      n_err++; $display("FAIL bypass_load_first: got ok=%b we=%b expected ok=1 we=0", ok, mem_bus.mem_we);
    end
    mem_pulse(32'hCAFE_F00D);
    n_cmp++; if (read_data !== 32'hCAFE_F00D || clk_stall !== 1'b0) begin
      n_err++; $display("FAIL bypass_read: got data=%h stall=%b expected data=%h stall=0", read_data, clk_stall, 32'hCAFE_F00D);
    end
    cpu_idle();
    wait_req(ok);
    n_cmp++; if (ok !== 1'b1 || mem_bus.mem_we !== 1'b1 || mem_bus.mem_addr !== 32'h1000) begin
      n_err++; $display("FAIL bypass_store_after: got ok=%b we=%b addr=%h expected ok=1 we=1 addr=%h", ok, mem_bus.mem_we, mem_bus.mem_addr, 32'h1000);
    end
    mem_pulse(32'h0);
  endtask

  task automatic test_reset_in_drain();
    bit ok;
    drive_store(32'h3000, 32'h99, 4'hF);
    @(negedge clk);
    cpu_idle();
    wait_req(ok);
    n_cmp++; if (ok !== 1'b1 || mem_bus.mem_we !== 1'b1) begin
      n_err++; $display("FAIL rst_drain_active: got ok=%b we=%b expected ok=1 we=1", ok, mem_bus.mem_we);
    end
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_drain_req: got %b expected 0", mem_bus.mem_req); end
    n_cmp++; if (dut.count_s !== 3'd0) begin n_err++; $display("FAIL rst_drain_count: got %0d expected 0", dut.count_s); end
    reset = 1'b0;
    mem_pulse(32'h0);
    repeat (3) @(negedge clk);
    n_cmp++; if (mem_bus.mem_req !== 1'b0) begin n_err++; $display("FAIL rst_drain_lost: got %b expected 0", mem_bus.mem_req); end
  endtask

  task automatic test_byte_store();
    bit ok;
    drive_store(32'h2000, 32'hAB, 4'b0001);
    exp_q.push_back('{1'b1, 32'h2000, 32'hAB, 4'b0001});
    @(negedge clk);
    cpu_idle();
    wait_req(ok);
    n_cmp++; if (ok !== 1'b1 || mem_bus.mem_sign_mask !== 4'b0001 || mem_bus.mem_addr !== 32'h2000) begin
      n_err++; $display("FAIL byte_store: got ok=%b mask=%b addr=%h expected ok=1 mask=0001 addr=%h", ok, mem_bus.mem_sign_mask, mem_bus.mem_addr, 32'h2000);
    end
    mem_pulse(32'h0);
  endtask

  initial begin
    mem_bus.mem_ready = 1'b0;
    mem_bus.mem_rdata = 32'h0;
    test_reset();
    test_fill_stall();
    test_hazard();
    test_bypass();
    test_reset_in_drain();
    test_byte_store();
    repeat (2) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_drained: got %0d pending expected 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
